wb_arbiter2: RTL and testbench
==============================

WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles a granted transfer waits for slave ACK/ERR.
REQ-002 Parameter ADDR_W, default 32; DAT_W, default 32; widths carried on the WB4 interface.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 m0  WB4 slave modport  -  requester 0, e.g. CPU data port.
REQ-006 m1  WB4 slave modport  -  requester 1, e.g. debug/test master.
REQ-007 s  WB4 master modport  -  shared slave port to the console peripheral.
REQ-008 grant  output  2  one-hot owner indication: bit0=m0, bit1=m1, 00=idle.

Function
REQ-009 States SHALL be IDLE, GNT0, GNT1, ABORT.
REQ-010 IDLE: a master requests when its CYC=1; the state SHALL move to GNTn on the next edge.
REQ-011 Single requester in IDLE SHALL be granted regardless of priority.
REQ-012 Both requesting in IDLE: the master not granted last SHALL win (round-robin); last_owner SHALL update on each grant.
REQ-013 Grant latency SHALL be exactly 1 cycle from CYC sampled high in IDLE to grant/state change.
REQ-014 In GNTn: s.CYC, STB, WE, ADR, DAT_W, SEL SHALL be combinationally driven from master n.
REQ-015 In GNTn: master n ACK/ERR/DAT_R SHALL be combinationally driven from s.
REQ-016 Non-owner master: ACK=0, ERR=0, DAT_R=0 at all times.
REQ-017 IDLE and ABORT: s.CYC=0, s.STB=0.
REQ-018 Ownership SHALL persist while the owner holds CYC=1, across multiple STB/ACK beats (bus lock).
REQ-019 Owner drops CYC: the state SHALL return to IDLE on the next edge; no back-to-back regrant in the same cycle.
REQ-020 Watchdog counter SHALL reset to 0 on every ACK, ERR, or owner STB=0, and SHALL increment on each owner STB=1 cycle without ACK/ERR.
REQ-021 Counter reaching TIMEOUT SHALL move GNTn->ABORT.
REQ-022 ABORT SHALL assert ERR=1 to the former owner for exactly one cycle, then go to IDLE.
REQ-023 Counter SHALL saturate, never wrap; width SHALL be clog2(TIMEOUT+1).
REQ-024 Slave ACK and ERR in the same cycle SHALL both be forwarded unmodified; the arbiter takes no action.
REQ-025 Requester CYC arriving during ABORT SHALL wait; arbitration resumes in IDLE.

Reset
REQ-026 rst=1 SHALL force state=IDLE, grant=00, watchdog=0, last_owner=m1, so m0 wins the first contention.
REQ-027 rst asserted mid-transfer SHALL drop s.CYC/STB in the same cycle as outputs follow IDLE combinationally; no ERR is issued.
REQ-028 All outputs SHALL be 0 while rst=1.

Structure
REQ-029 The arb_state_t enum and the WB4 signal field widths SHALL live in the shared bus package.
REQ-030 The watchdog SHALL be a sub-module wb_watchdog (inputs: clear, tick; output: expired).
REQ-031 The FSM and muxing SHALL be in wb_arbiter2; no other sub-modules.

Verification
REQ-032 Only m0 writes 0x41 to console: grant=01 one cycle after CYC; slave sees DAT_W=0x41; m0 gets ACK; m1 sees ACK=0.
REQ-033 m0 and m1 raise CYC together after reset: m0 is granted first; after m0 drops CYC, IDLE for one cycle, then m1 is granted.
REQ-034 Repeat REQ-033 contention twice more: grants alternate m1, then m0.
REQ-035 m0 holds CYC for 3 beats with m1 requesting: grant stays 01 for all 3 ACKs.
REQ-036 Slave never acks with TIMEOUT=8: m0 sees ERR one cycle after 8 unacked STB cycles; s.CYC=0 in ABORT; next state is IDLE.
REQ-037 rst pulsed during a GNT1 wait: grant=00, s.CYC=0, m1 ERR never asserted.

Source files
------------

// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone B4 console arbiter.
package wb_arbiter2_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DAT_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  // One byte-select bit per byte lane of the data bus.
  function automatic int sel_w(input int dat_w);
    return (dat_w + 7) / 8;
  endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// Wishbone B4 classic bus bundle; master drives the request, slave drives the response.
interface wb_arbiter2_if
  import wb_arbiter2_pkg::*;
#(
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DAT_W  = WB_DAT_W
) ();

  localparam int SEL_W = sel_w(DAT_W);

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DAT_W-1:0]  dat_w;
  logic [SEL_W-1:0]  sel;
  logic              ack;
  logic              err;
  logic [DAT_W-1:0]  dat_r;

  modport master (output cyc, stb, we, adr, dat_w, sel, input ack, err, dat_r);
  modport slave  (input cyc, stb, we, adr, dat_w, sel, output ack, err, dat_r);

endinterface

// File: rtl/wb_arbiter2_watchdog.sv
// Saturating stall counter; flags the edge on which a granted transfer runs out of patience.
module wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clear)
      cnt_nxt = '0;
    else if (tick && cnt != LIMIT)
      cnt_nxt = cnt + CW'(1);
  end

  // Looks at the next count so the FSM aborts on the same edge the count lands on TIMEOUT.
  assign expired = (cnt_nxt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin arbiter giving two Wishbone masters locked access to one console slave, with stall abort.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DAT_W   = WB_DAT_W
) (
  input  logic                clk,
  input  logic                rst,
  wb_arbiter2_if.slave        m0,
  wb_arbiter2_if.slave        m1,
  wb_arbiter2_if.master       s,
  output logic [1:0]          grant
);

  localparam int SEL_W = sel_w(DAT_W);

  arb_state_t        state;
  logic [1:0]        grant_q;
  logic              last_owner;
  logic              own0, own1, own, abort0, abort1;
  logic              tick, expired;
  logic [ADDR_W-1:0] adr_mux;
  logic [DAT_W-1:0]  dat_mux;
  logic [SEL_W-1:0]  sel_mux;

  // Reset gates every path so the slave sees CYC drop in the reset cycle itself.
  assign own0   = !rst && (state == GNT0);
  assign own1   = !rst && (state == GNT1);
  assign own    = own0 | own1;
  assign abort0 = !rst && (state == ABORT) && !last_owner;
  assign abort1 = !rst && (state == ABORT) &&  last_owner;
  assign grant  = rst ? 2'b00 : grant_q;

  assign adr_mux = own1 ? m1.adr   : m0.adr;
  assign dat_mux = own1 ? m1.dat_w : m0.dat_w;
  assign sel_mux = own1 ? m1.sel   : m0.sel;

  assign s.cyc   = (own0 & m0.cyc) | (own1 & m1.cyc);
  assign s.stb   = (own0 & m0.stb) | (own1 & m1.stb);
  assign s.we    = (own0 & m0.we)  | (own1 & m1.we);
  assign s.adr   = own ? adr_mux : '0;
  assign s.dat_w = own ? dat_mux : '0;
  assign s.sel   = own ? sel_mux : '0;

  assign m0.ack   = own0 & s.ack;
  assign m0.err   = (own0 & s.err) | abort0;
  assign m0.dat_r = own0 ? s.dat_r : '0;
  assign m1.ack   = own1 & s.ack;
  assign m1.err   = (own1 & s.err) | abort1;
  assign m1.dat_r = own1 ? s.dat_r : '0;

  // A cycle counts as a stall only while the owner strobes and the slave stays silent.
  assign tick = s.stb & ~s.ack & ~s.err;

  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (~tick),
    .tick    (tick),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_q    <= 2'b00;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (m0.cyc && (!m1.cyc || last_owner)) begin
            state      <= GNT0;
            grant_q    <= 2'b01;
            last_owner <= 1'b0;
          end else if (m1.cyc) begin
            state      <= GNT1;
            grant_q    <= 2'b10;
            last_owner <= 1'b1;
          end
        end
        GNT0: begin
          if (!m0.cyc || expired) begin
            state   <= m0.cyc ? ABORT : IDLE;
            grant_q <= 2'b00;
          end
        end
        GNT1: begin
          if (!m1.cyc || expired) begin
            state   <= m1.cyc ? ABORT : IDLE;
            grant_q <= 2'b00;
          end
        end
        ABORT: begin
          state   <= IDLE;
          grant_q <= 2'b00;
        end
        default: begin
          state   <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: reset, single write, round-robin, bus lock, timeout abort, reset mid-wait.
module tb_wb_arbiter2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  int         checks = 0;
  int         errors = 0;

  wb_arbiter2_if #(.ADDR_W(32), .DAT_W(32)) m0_bus ();
  wb_arbiter2_if #(.ADDR_W(32), .DAT_W(32)) m1_bus ();
  wb_arbiter2_if #(.ADDR_W(32), .DAT_W(32)) s_bus ();

  wb_arbiter2 #(.TIMEOUT(8), .ADDR_W(32), .DAT_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus),
    .grant (grant)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_bus.cyc = 0; m0_bus.stb = 0; m0_bus.we = 0; m0_bus.adr = 0; m0_bus.dat_w = 0; m0_bus.sel = 0;
    m1_bus.cyc = 0; m1_bus.stb = 0; m1_bus.we = 0; m1_bus.adr = 0; m1_bus.dat_w = 0; m1_bus.sel = 0;
    s_bus.ack = 0; s_bus.err = 0; s_bus.dat_r = 0;
  endtask

  task automatic do_reset();
    idle_masters();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_masters();
    rst = 1;
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.dat_w = 32'h55;
    s_bus.ack = 1; s_bus.dat_r = 32'hFFFF_FFFF;
    step();
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
    checks++; if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0) begin errors++; $display("FAIL rst_s_cyc_stb: got %b%b want 00", s_bus.cyc, s_bus.stb); end
    checks++; if (m0_bus.ack !== 1'b0 || m0_bus.dat_r !== 32'h0) begin errors++; $display("FAIL rst_m0_resp: got ack=%b dat_r=%h want 0", m0_bus.ack, m0_bus.dat_r); end
    checks++; if (s_bus.dat_w !== 32'h0) begin errors++; $display("FAIL rst_s_dat_w: got %h want 0", s_bus.dat_w); end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.we = 1; m0_bus.adr = 32'h1000; m0_bus.dat_w = 32'h41; m0_bus.sel = 4'h1;
    #1;
    checks++; if (grant !== 2'b00 || s_bus.cyc !== 1'b0) begin errors++; $display("FAIL wr_latency: got grant=%b cyc=%b want 00/0", grant, s_bus.cyc); end
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL wr_grant: got %b want 01", grant); end
    checks++; if (s_bus.cyc !== 1'b1 || s_bus.we !== 1'b1 || s_bus.adr !== 32'h1000) begin errors++; $display("FAIL wr_s_ctrl: got cyc=%b we=%b adr=%h", s_bus.cyc, s_bus.we, s_bus.adr); end
    checks++; if (s_bus.dat_w !== 32'h41 || s_bus.sel !== 4'h1) begin errors++; $display("FAIL wr_s_data: got dat=%h sel=%h want 41/1", s_bus.dat_w, s_bus.sel); end
    s_bus.ack = 1; s_bus.dat_r = 32'h5A;
    #1;
    checks++; if (m0_bus.ack !== 1'b1 || m0_bus.dat_r !== 32'h5A) begin errors++; $display("FAIL wr_m0_ack: got ack=%b dat_r=%h want 1/5a", m0_bus.ack, m0_bus.dat_r); end
    checks++; if (m1_bus.ack !== 1'b0 || m1_bus.dat_r !== 32'h0) begin errors++; $display("FAIL wr_m1_quiet: got ack=%b dat_r=%h want 0/0", m1_bus.ack, m1_bus.dat_r); end
    step();
    m0_bus.cyc = 0; m0_bus.stb = 0; s_bus.ack = 0;
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wr_release: got %b want 00", grant); end
  endtask

  task automatic test_round_robin();
    int own;
    do_reset();
    m0_bus.cyc = 1; m0_bus.stb = 1; m0_bus.dat_w = 32'h11;
    m1_bus.cyc = 1; m1_bus.stb = 1; m1_bus.dat_w = 32'h22;
    own = 0;
    for (int r = 0; r < 4; r++) begin
      step();
      checks++; if (grant !== (own ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant round %0d: got %b want %b", r, grant, own ? 2'b10 : 2'b01); end
      checks++; if (s_bus.dat_w !== (own ? 32'h22 : 32'h11)) begin errors++; $display("FAIL rr_route round %0d: got %h", r, s_bus.dat_w); end
      s_bus.ack = 1;
      #1;
      checks++; if ({m1_bus.ack, m0_bus.ack} !== (own ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_ack round %0d: got m1=%b m0=%b", r, m1_bus.ack, m0_bus.ack); end
      step();
      s_bus.ack = 0;
      if (own != 0) begin m1_bus.cyc = 0; m1_bus.stb = 0; end
      else          begin m0_bus.cyc = 0; m0_bus.stb = 0; end
      step();
      checks++; if (grant !== 2'b00 || s_bus.cyc !== 1'b0) begin errors++; $display("FAIL rr_idle round %0d: got grant=%b cyc=%b want 00/0", r, grant, s_bus.cyc); end
      if (own != 0) begin m1_bus.cyc = 1; m1_bus.stb = 1; end
      else          begin m0_bus.cyc = 1; m0_bus.stb = 1; end
      own = 1 - own;
    end
    idle_masters();
    step();
  endtask

  task automatic test_bus_lock();
    do_reset();
    m0_bus.cyc = 1; m0_bus.stb = 1;
    m1_bus.cyc = 1; m1_bus.stb = 1;
    step();
    s_bus.ack = 1;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) step();
      #1;
      checks++; if (grant !== 2'b01 || m0_bus.ack !== 1'b1 || m1_bus.ack !== 1'b0) begin errors++; $display("FAIL lock_beat %0d: got grant=%b m0ack=%b m1ack=%b", b, grant, m0_bus.ack, m1_bus.ack); end
    end
    m0_bus.cyc = 0; m0_bus.stb = 0; s_bus.ack = 0;
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL lock_release: got %b want 00", grant); end
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL lock_next: got %b want 10", grant); end
    idle_masters();
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    m0_bus.cyc = 1; m0_bus.stb = 1;
    step();
    checks++; if (grant !== 2'b01 || m0_bus.err !== 1'b0) begin errors++; $display("FAIL to_start: got grant=%b err=%b", grant, m0_bus.err); end
    for (int i = 1; i < 8; i++) begin
      step();
      checks++; if (grant !== 2'b01 || m0_bus.err !== 1'b0) begin errors++; $display("FAIL to_wait %0d: got grant=%b err=%b", i, grant, m0_bus.err); end
    end
    step();
    checks++; if (m0_bus.err !== 1'b1) begin errors++; $display("FAIL to_abort_err: got %b want 1", m0_bus.err); end
    checks++; if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL to_abort_bus: got cyc=%b stb=%b grant=%b", s_bus.cyc, s_bus.stb, grant); end
    checks++; if (m1_bus.err !== 1'b0) begin errors++; $display("FAIL to_abort_m1: got %b want 0", m1_bus.err); end
    m0_bus.cyc = 0; m0_bus.stb = 0;
    m1_bus.cyc = 1; m1_bus.stb = 1;
    step();
    checks++; if (m0_bus.err !== 1'b0 || grant !== 2'b00 || s_bus.cyc !== 1'b0) begin errors++; $display("FAIL to_idle: got err=%b grant=%b cyc=%b", m0_bus.err, grant, s_bus.cyc); end
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL to_resume: got %b want 10", grant); end
    s_bus.ack = 1; s_bus.err = 1; s_bus.dat_r = 32'h77;
    #1;
    checks++; if (m1_bus.ack !== 1'b1 || m1_bus.err !== 1'b1 || m1_bus.dat_r !== 32'h77) begin errors++; $display("FAIL ackerr_fwd: got ack=%b err=%b dat=%h", m1_bus.ack, m1_bus.err, m1_bus.dat_r); end
    checks++; if (m0_bus.err !== 1'b0 || m0_bus.ack !== 1'b0) begin errors++; $display("FAIL ackerr_m0: got ack=%b err=%b want 0/0", m0_bus.ack, m0_bus.err); end
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL ackerr_hold: got %b want 10", grant); end
    idle_masters();
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ackerr_release: got %b want 00", grant); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_bus.cyc = 1; m1_bus.stb = 1;
    step();
    checks++; if (grant !== 2'b10 || s_bus.cyc !== 1'b1) begin errors++; $display("FAIL rm_grant: got grant=%b cyc=%b want 10/1", grant, s_bus.cyc); end
    step();
    step();
    rst = 1;
    #1;
    checks++; if (s_bus.cyc !== 1'b0 || s_bus.stb !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rm_comb: got cyc=%b stb=%b grant=%b", s_bus.cyc, s_bus.stb, grant); end
    checks++; if (m1_bus.err !== 1'b0) begin errors++; $display("FAIL rm_err_comb: got %b want 0", m1_bus.err); end
    step();
    m1_bus.cyc = 0; m1_bus.stb = 0;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (m1_bus.err !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rm_after %0d: got err=%b grant=%b", i, m1_bus.err, grant); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1;
    idle_masters();
    test_reset();
    test_single_write();
    test_round_robin();
    test_bus_lock();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
